// File: rtl/inst_fetcher_if.sv
// Fetch-side bus: redirect input, icache lookup/fill, memory controller return
// and the decode handshake.
interface inst_fetcher_if;
  localparam int unsigned XLEN = 32;

  // redirect from execute/commit
  logic            jump_en;
  logic [XLEN-1:0] jump_addr;

  // icache lookup
  logic            ic_fetch_en;
  logic [XLEN-1:0] ic_fetch_addr;
  logic            ic_hit;
  logic [XLEN-1:0] ic_inst;

  // memory controller return and icache fill
  logic            mem_inst_valid;
  logic [XLEN-1:0] mem_inst;
  logic [XLEN-1:0] mem_inst_addr;
  logic            ic_add_en;
  logic [XLEN-1:0] ic_add_inst;
  logic [XLEN-1:0] ic_add_addr;
  logic            mem_discard;

  // decode handshake
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    input  jump_en, jump_addr,
    input  ic_hit, ic_inst,
    input  mem_inst_valid, mem_inst, mem_inst_addr,
    input  inst_ready,
    output ic_fetch_en, ic_fetch_addr,
    output ic_add_en, ic_add_inst, ic_add_addr, mem_discard,
    output inst_valid, inst, inst_pc
  );

  modport slave (
    output jump_en, jump_addr,
    output ic_hit, ic_inst,
    output mem_inst_valid, mem_inst, mem_inst_addr,
    output inst_ready,
    input  ic_fetch_en, ic_fetch_addr,
    input  ic_add_en, ic_add_inst, ic_add_addr, mem_discard,
    input  inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction-fetch front end: owns the PC, looks up the icache once per
// instruction, waits out misses, and hands one instruction at a time to decode.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetcher_if.master fetch_bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_MISS  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;
  logic            discard_q, discard_d;

  logic            slot_free_c;
  logic            fetch_en_c;
  logic            accept_c;
  logic            mem_match_c;
  logic [XLEN-1:0] pc_next_c;

  assign slot_free_c = !inst_valid_q || fetch_bus.inst_ready;
  assign accept_c    = inst_valid_q && fetch_bus.inst_ready;
  assign fetch_en_c  = (state_q == ST_FETCH) && slot_free_c && !fetch_bus.jump_en && !rst;
  assign mem_match_c = fetch_bus.mem_inst_valid && (fetch_bus.mem_inst_addr == pc_q);
  assign pc_next_c   = pc_q + XLEN'(PC_STEP);

  // State register and output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      discard_q    <= discard_d;
    end
  end

  // Next-state: a redirect overrides any hit or return seen in the same cycle
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    discard_d    = 1'b0;

    if (accept_c) begin
      inst_valid_d = 1'b0;
    end

    if (fetch_bus.jump_en) begin
      pc_d         = fetch_bus.jump_addr;
      inst_valid_d = 1'b0;
      state_d      = ST_FETCH;
      discard_d    = (state_q == ST_MISS);
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (fetch_en_c) begin
            if (fetch_bus.ic_hit) begin
              inst_d       = fetch_bus.ic_inst;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_next_c;
            end else begin
              state_d = ST_MISS;
            end
          end
        end
        ST_MISS: begin
          // Returns for any other address are stale and only fill the cache
          if (mem_match_c) begin
            inst_d       = fetch_bus.mem_inst;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_next_c;
            state_d      = ST_FETCH;
          end
        end
      endcase
    end
  end

  assign fetch_bus.ic_fetch_en   = fetch_en_c;
  assign fetch_bus.ic_fetch_addr = pc_q;

  // Every return is filled, stale or not, since the data is right for its address
  assign fetch_bus.ic_add_en   = fetch_bus.mem_inst_valid && !rst;
  assign fetch_bus.ic_add_inst = rst ? '0 : fetch_bus.mem_inst;
  assign fetch_bus.ic_add_addr = rst ? '0 : fetch_bus.mem_inst_addr;
  assign fetch_bus.mem_discard = discard_q;

  assign fetch_bus.inst_valid = inst_valid_q;
  assign fetch_bus.inst       = inst_q;
  assign fetch_bus.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized bench for inst_fetcher: icache and memory-controller models drive
// the DUT, a scoreboard checks the delivered instruction stream and protocol.
module tb_inst_fetcher;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          NCYC   = 4000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic hit_rnd;

  inst_fetcher_if bus ();

  inst_fetcher #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_bus (bus)
  );

  always #5 clk = ~clk;

  // Program image: every address holds a fixed pseudo-random word
  function automatic logic [31:0] prog(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign bus.ic_hit  = bus.ic_fetch_en & hit_rnd;
  assign bus.ic_inst = prog(bus.ic_fetch_addr);

  exp_t        exp_q[$];
  req_t        req_q[$];
  logic [31:0] push_pc;
  int          cyc;
  int          total = 0;
  int          bad   = 0;
  int          n_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    push_pc = start;
  endtask

  // Stimulus: decode readiness, hits, redirects, reset, memory returns
  initial begin : driver
    logic        pend_flush;
    logic [31:0] pend_target;
    logic [31:0] r;
    int          idx;
    pend_flush = 1'b0;
    pend_target = '0;
    cyc = 0;
    rst = 1'b1;
    hit_rnd = 1'b0;
    bus.jump_en = 1'b0;
    bus.jump_addr = '0;
    bus.inst_ready = 1'b0;
    bus.mem_inst_valid = 1'b0;
    bus.mem_inst = '0;
    bus.mem_inst_addr = '0;
    restart_stream(RST_PC);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc++;
      // a redirect takes effect after the cycle it was raised in
      if (pend_flush) restart_stream(pend_target);
      rst = (cyc >= 2000 && cyc < 2002);
      if (rst) restart_stream(RST_PC);

      bus.inst_ready = ($urandom % 4) != 0;
      hit_rnd        = ($urandom % 10) < 7;
      bus.jump_en    = !rst && (($urandom % 14) == 0);
      r = $urandom;
      case ($urandom % 4)
        0:       bus.jump_addr = 32'hFFFF_FFF4;
        1:       bus.jump_addr = {24'h0, r[7:2], 2'b00};
        default: bus.jump_addr = {r[31:2], 2'b00};
      endcase
      pend_flush  = bus.jump_en;
      pend_target = bus.jump_addr;

      idx = -1;
      for (int i = 0; i < req_q.size(); i++) begin
        if (idx < 0 && req_q[i].due <= cyc) idx = i;
      end
      if (idx >= 0) begin
        bus.mem_inst_valid = 1'b1;
        bus.mem_inst_addr  = req_q[idx].addr;
        req_q.delete(idx);
      end else if (($urandom % 25) == 0) begin
        bus.mem_inst_valid = 1'b1;
        bus.mem_inst_addr  = {r[31:2], 2'b10};
      end else begin
        bus.mem_inst_valid = 1'b0;
        bus.mem_inst_addr  = r;
      end
      bus.mem_inst = prog(bus.mem_inst_addr);

      while (exp_q.size() < 8) begin
        exp_q.push_back('{pc: push_pc, ins: prog(push_pc)});
        push_pc = push_pc + 32'd4;
      end

      #2;
      if (!rst && bus.ic_fetch_en && !bus.ic_hit)
        req_q.push_back('{addr: bus.ic_fetch_addr, due: cyc + int'($urandom_range(1, 6))});
    end
    @(negedge clk);
    bus.jump_en = 1'b0;
    #4;
    total++;
    if (n_acc < 200) begin
      bad++;
      $display("FAIL throughput: got %0d accepted want at least 200", n_acc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: fetch/miss/redirect model plus scoreboard of accepted instructions
  initial begin : monitor
    logic [31:0] fpc;
    logic        waiting;
    logic        exp_disc;
    logic        exp_fe;
    logic        prev_stall;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    exp_t        e;
    fpc = RST_PC;
    waiting = 1'b0;
    exp_disc = 1'b0;
    prev_stall = 1'b0;
    prev_inst = '0;
    prev_pc = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_discard", 32'(bus.mem_discard), 32'd0);
        check("rst_fetch_en", 32'(bus.ic_fetch_en), 32'd0);
        check("rst_fetch_addr", bus.ic_fetch_addr, RST_PC);
        check("rst_add_en", 32'(bus.ic_add_en), 32'd0);
        fpc = RST_PC;
        waiting = 1'b0;
        exp_disc = 1'b0;
        prev_stall = 1'b0;
      end else begin
        check("mem_discard", 32'(bus.mem_discard), 32'(exp_disc));
        check("ic_add_en", 32'(bus.ic_add_en), 32'(bus.mem_inst_valid));
        if (bus.mem_inst_valid) begin
          check("ic_add_addr", bus.ic_add_addr, bus.mem_inst_addr);
          check("ic_add_inst", bus.ic_add_inst, prog(bus.mem_inst_addr));
        end
        if (prev_stall) begin
          check("stall_valid", 32'(bus.inst_valid), 32'd1);
          check("stall_inst", bus.inst, prev_inst);
          check("stall_pc", bus.inst_pc, prev_pc);
        end
        exp_fe = !waiting && (!bus.inst_valid || bus.inst_ready) && !bus.jump_en;
        check("ic_fetch_en", 32'(bus.ic_fetch_en), 32'(exp_fe));
        if (exp_fe) check("ic_fetch_addr", bus.ic_fetch_addr, fpc);

        if (bus.inst_valid && bus.inst_ready) begin
          n_acc++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stream: got pc %h with no expected entry", bus.inst_pc);
          end else begin
            e = exp_q.pop_front();
            check("inst_pc", bus.inst_pc, e.pc);
            check("inst", bus.inst, e.ins);
          end
        end

        exp_disc = bus.jump_en && waiting;
        if (bus.jump_en) begin
          fpc = bus.jump_addr;
          waiting = 1'b0;
        end else if (waiting) begin
          if (bus.mem_inst_valid && bus.mem_inst_addr == fpc) begin
            waiting = 1'b0;
            fpc = fpc + 32'd4;
          end
        end else if (exp_fe) begin
          if (hit_rnd) fpc = fpc + 32'd4;
          else waiting = 1'b1;
        end
        prev_stall = bus.inst_valid && !bus.inst_ready && !bus.jump_en;
        prev_inst  = bus.inst;
        prev_pc    = bus.inst_pc;
      end
    end
  end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Instruction-fetch front end: owns the PC, issues one lookup per instruction to the icache, and tracks the miss that the icache forwards to the memory controller.
- Accepts the controller's instruction return, fills the icache, and presents one instruction at a time to the decode/issue stage over a valid/ready handshake.
- Handles branch/jump redirects, including cancelling an in-flight miss.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- jump_en  in  1  redirect pulse from execute/commit
- jump_addr  in  32  redirect target
- ic_fetch_en  out  1  icache lookup request (icache fetchEn)
- ic_fetch_addr  out  32  lookup address (icache Addr)
- ic_hit  in  1  icache hit, combinational in the same cycle as ic_fetch_en
- ic_inst  in  32  icache hit data
- mem_inst_valid  in  1  memory controller instruction return pulse (instOutEn)
- mem_inst  in  32  returned instruction
- mem_inst_addr  in  32  address of returned instruction (controller addAddr)
- ic_add_en  out  1  icache fill enable
- ic_add_inst  out  32  fill data
- ic_add_addr  out  32  fill address
- mem_discard  out  1  cancel in-flight instruction read (controller Discard[0])
- inst_valid  out  1  instruction available to decode
- inst  out  32  instruction
- inst_pc  out  32  PC of inst
- inst_ready  in  1  decode accepts inst this cycle

Behaviour:
- Reset (async):
  - pc=RESET_PC; state=FETCH; inst_valid=0; inst=0; inst_pc=0; mem_discard=0.
  - Combinational outputs evaluate low/zero while rst is high.
- States:
  - FETCH: ready to issue a lookup.
  - MISS: waiting for the memory return for pc.
- Output slot: a single register (inst, inst_pc, inst_valid).
  - slot_free = !inst_valid | inst_ready.
  - On an accept (inst_valid & inst_ready) with no new fill in the same cycle, inst_valid clears next edge.
- ic_fetch_en = (state==FETCH) & slot_free & !jump_en & !rst. ic_fetch_addr = pc (always driven).
  - A lookup is a single-cycle request; the fetcher never holds ic_fetch_en high across a miss, so the controller receives exactly one request per miss.
- FETCH with ic_fetch_en=1:
  - If ic_hit: next edge loads inst=ic_inst, inst_pc=pc, inst_valid=1, pc+=PC_STEP; state stays FETCH. Throughput is 1 instr/cycle while hitting and decode is ready.
  - If miss: state→MISS; pc unchanged.
- MISS:
  - Acceptance condition: mem_inst_valid & (mem_inst_addr==pc).
  - When the condition holds, next edge loads inst=mem_inst, inst_pc=pc, inst_valid=1, pc+=PC_STEP; state→FETCH.
  - The output slot is always free in MISS: entry to MISS required slot_free, and no fill occurs while in MISS.
  - A return with a non-matching address is a stale request: it does not update the output or state.
- Cache fill:
  - ic_add_en = mem_inst_valid in any state; ic_add_inst = mem_inst; ic_add_addr = mem_inst_addr.
  - Stale returns are still filled, since the data is correct for its address.
- Redirect (jump_en=1), highest priority, next edge:
  - pc=jump_addr; inst_valid=0; state=FETCH.
  - Any same-cycle hit or mem return is not presented to decode; the mem return is still filled into the cache.
  - mem_discard: registered 1-cycle pulse on the edge after jump_en when state was MISS, otherwise 0.
  - The first lookup at the target occurs in the cycle after jump_en.
- Back-to-back jumps: last one wins; each jump seen in MISS produces its own discard pulse.
- pc arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Stall: with inst_valid=1 and inst_ready=0, outputs hold stable, pc holds, and no lookup is issued.
- Reset mid-MISS: returns to FETCH at RESET_PC. Late returns are filtered by the address compare (unless the address equals RESET_PC, in which case the data is correct).

Test Plan:
- Reset, RESET_PC=0, icache hits at 0,4,8 with inst_ready=1: inst_pc 0,4,8 on consecutive cycles; ic_fetch_en high 3 cycles; no ic_add_en.
- Miss at 0x10, mem returns 0x00A00093 @0x10 five cycles later: ic_fetch_en high exactly 1 cycle; inst=0x00A00093, inst_pc=0x10 the cycle after return; ic_add_en pulse with addr 0x10.
- Hit with inst_ready=0 for 3 cycles: inst/inst_pc stable, ic_fetch_en=0, pc unchanged; resumes the cycle after inst_ready rises.
- Miss at 0x20, jump_en to 0x100 two cycles later: mem_discard 1-cycle pulse; a later return @0x20 fills the cache but produces no inst_valid; next lookup at 0x100.
- jump_en coincident with a hit at 0x40: hit instruction dropped; inst_valid=0 next cycle; lookup at jump target the following cycle.
- pc=0xFFFF_FFFC hit: next ic_fetch_addr=0x0000_0000.
